// File: rtl/pc_gen_if.sv
// Fetch-side handshake between the PC generator (master) and instruction memory (slave).
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus_o;
    logic            pc_valid_o;

    modport master (
        input  fetch_ready_i,
        output pc_o,
        output pc_plus_o,
        output pc_valid_o
    );

    modport slave (
        output fetch_ready_i,
        input  pc_o,
        input  pc_plus_o,
        input  pc_valid_o
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: boot delay, stall/handshake hold, prioritised trap/redirect, flush pulse.
// Optional PC_GEN_MISALIGN_TRAP_EN: misaligned redirect targets are reported instead of loaded.
module pc_gen_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     INC         = 4,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int unsigned     BOOT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    pc_gen_if.master        fetch,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_base_i,
    input  logic [XLEN-1:0] redirect_offset_i,
    input  logic            redirect_jalr_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
`ifdef PC_GEN_MISALIGN_TRAP_EN
    output logic            misalign_o,
`endif
    output logic            flush_o,
    output logic [15:0]     redirect_cnt_o
);

    typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

    state_e          state_q;
    logic [3:0]      boot_cnt_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            flush_q;
    logic [15:0]     cnt_q;
    logic [XLEN-1:0] target;
    logic            target_bad;
    logic            applied;

    always_comb begin
        target = redirect_base_i + redirect_offset_i;
        if (redirect_jalr_i) begin
            target[0] = 1'b0;
        end
    end

`ifdef PC_GEN_MISALIGN_TRAP_EN
    // A trap in the same cycle wins, so the target is irrelevant then.
    assign target_bad = redirect_valid_i && !trap_valid_i && (target[1:0] != 2'b00);
`else
    assign target_bad = 1'b0;
`endif

    assign applied = trap_valid_i || redirect_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            boot_cnt_q <= '0;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                StBoot: begin
                    flush_q <= 1'b0;
                    if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                        state_q <= StRun;
                        valid_q <= 1'b1;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 4'd1;
                    end
                end
                default: begin
                    valid_q <= 1'b1;
                    flush_q <= applied;
                    if (applied) begin
                        // The outstanding request is dropped, not replayed.
                        state_q <= StRun;
                        if (!target_bad) begin
                            pc_q <= trap_valid_i ? trap_vector_i : target;
                            if (cnt_q != 16'hFFFF) begin
                                cnt_q <= cnt_q + 16'd1;
                            end
                        end
                    end else if (stall_i) begin
                        state_q <= StHold;
                    end else if (fetch.fetch_ready_i) begin
                        state_q <= StRun;
                        pc_q    <= pc_q + XLEN'(INC);
                    end else begin
                        state_q <= StHold;
                    end
                end
            endcase
        end
    end

`ifdef PC_GEN_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q != StBoot) && target_bad;
        end
    end

    assign misalign_o = misalign_q;
`endif

    assign fetch.pc_o       = pc_q;
    assign fetch.pc_plus_o  = pc_q + XLEN'(INC);
    assign fetch.pc_valid_o = valid_q;
    assign flush_o          = flush_q;
    assign redirect_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rbase;
    logic [31:0] roff;
    logic        rjalr;
    logic        tv;
    logic [31:0] tvec;
    logic        flush;
    logic [15:0] rcnt;
    logic        misalign;

    pc_gen_if #(.XLEN(32)) fif ();

    always #5 clk = ~clk;

    pc_gen_unit #(
        .XLEN        (32),
        .INC         (4),
        .RESET_VEC   (32'h0000_0000),
        .BOOT_CYCLES (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch             (fif),
        .stall_i           (stall),
        .redirect_valid_i  (rv),
        .redirect_base_i   (rbase),
        .redirect_offset_i (roff),
        .redirect_jalr_i   (rjalr),
        .trap_valid_i      (tv),
        .trap_vector_i     (tvec),
`ifdef PC_GEN_MISALIGN_TRAP_EN
        .misalign_o        (misalign),
`endif
        .flush_o           (flush),
        .redirect_cnt_o    (rcnt)
    );

`ifndef PC_GEN_MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        f;
        logic [15:0] c;
        logic        m;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] ec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", fif.pc_o, e.pc);
            chk("pc_plus", fif.pc_plus_o, e.pc + 32'd4);
            chk("pc_valid", {31'd0, fif.pc_valid_o}, {31'd0, e.v});
            chk("flush", {31'd0, flush}, {31'd0, e.f});
            chk("redirect_cnt", {16'd0, rcnt}, {16'd0, e.c});
`ifdef PC_GEN_MISALIGN_TRAP_EN
            chk("misalign", {31'd0, misalign}, {31'd0, e.m});
`endif
        end
    end

    // Apply current inputs across one rising edge, then queue what must be seen after it.
    task automatic tick(input logic [31:0] pc, input logic v, input logic f,
                        input logic [15:0] c, input logic m = 1'b0);
        exp_t e;
        @(posedge clk);
        e.pc = pc; e.v = v; e.f = f; e.c = c; e.m = m;
        q.push_back(e);
        #1;
    endtask

    task automatic redir(input logic [31:0] b, input logic [31:0] o, input logic j);
        rv = 1'b1; rbase = b; roff = o; rjalr = j;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; rbase = '0; roff = '0; rjalr = 1'b0;
        tv = 1'b0; tvec = '0; fif.fetch_ready_i = 1'b1;
        tick(32'h0, 1'b0, 1'b0, 16'd0);
        tick(32'h0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        tick(32'h0, 1'b1, 1'b0, 16'd0);
        tick(32'h4, 1'b1, 1'b0, 16'd0);
        tick(32'h8, 1'b1, 1'b0, 16'd0);

        // Jump to 0x100, then hold on an unaccepted handshake
        redir(32'h100, 32'h0, 1'b0);
        tick(32'h100, 1'b1, 1'b1, 16'd1);
        rv = 1'b0; fif.fetch_ready_i = 1'b0;
        repeat (3) tick(32'h100, 1'b1, 1'b0, 16'd1);
        fif.fetch_ready_i = 1'b1;
        tick(32'h104, 1'b1, 1'b0, 16'd1);
        stall = 1'b1;
        repeat (2) tick(32'h104, 1'b1, 1'b0, 16'd1);

        // Redirect with negative offset overrides the stall
        redir(32'h200, 32'hFFFF_FFF0, 1'b0);
        tick(32'h1F0, 1'b1, 1'b1, 16'd2);
        rv = 1'b0; stall = 1'b0;
        tick(32'h1F4, 1'b1, 1'b0, 16'd2);
        redir(32'h301, 32'h0, 1'b1);
        tick(32'h300, 1'b1, 1'b1, 16'd3);

        redir(32'h202, 32'h0, 1'b0);
`ifdef PC_GEN_MISALIGN_TRAP_EN
        tick(32'h300, 1'b1, 1'b1, 16'd3, 1'b1);
        rv = 1'b0;
        tick(32'h304, 1'b1, 1'b0, 16'd3, 1'b0);
        ec = 16'd3;
`else
        tick(32'h202, 1'b1, 1'b1, 16'd4);
        rv = 1'b0;
        tick(32'h206, 1'b1, 1'b0, 16'd4);
        ec = 16'd4;
`endif

        // Trap and redirect together: trap wins, counted once
        redir(32'h400, 32'h0, 1'b0); tv = 1'b1; tvec = 32'h8000_0000;
        ec = ec + 16'd1;
        tick(32'h8000_0000, 1'b1, 1'b1, ec);
        tv = 1'b0;

        // Wrap at the top of the address space
        redir(32'hFFFF_FFF0, 32'hC, 1'b0);
        ec = ec + 16'd1;
        tick(32'hFFFF_FFFC, 1'b1, 1'b1, ec);
        rv = 1'b0;
        tick(32'h0, 1'b1, 1'b0, ec);

        // Counter saturation
        redir(32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 65536; i++) begin
            if (ec != 16'hFFFF) ec = ec + 16'd1;
            tick(32'h10, 1'b1, 1'b1, ec);
        end
        rv = 1'b0; fif.fetch_ready_i = 1'b0;
        tick(32'h10, 1'b1, 1'b0, 16'hFFFF);

        // Reset in HOLD with a redirect pending
        rst = 1'b1; redir(32'h500, 32'h0, 1'b0);
        tick(32'h0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0; fif.fetch_ready_i = 1'b1;
        tick(32'h0, 1'b1, 1'b0, 16'd0);
        rv = 1'b0;
        tick(32'h4, 1'b1, 1'b0, 16'd0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the pipelined RV32I core; sits at the head of IF.
- Holds the architectural fetch PC and computes the sequential next PC (PC+INC) and branch/jump targets (base+offset, JALR LSB clear).
- Selects the next PC by fixed priority and presents it to instruction memory through a valid/ready handshake.
- Generalises the plain 32-bit adder to an XLEN-wide, stall-, flush- and trap-aware PC register.

Parameters:
- XLEN, 32, datapath width of PC, targets and adders.
- INC, 4, sequential increment in bytes (power of two, >= 2).
- RESET_VEC, 32'h0000_0000, PC value loaded by reset (XLEN bits).
- BOOT_CYCLES, 1, cycles pc_valid_o stays low after reset release (1..15).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- fetch_ready_i  in  1  IMEM accepts pc_o this cycle.
- stall_i  in  1  pipeline hazard stall; freezes PC.
- redirect_valid_i  in  1  taken branch/jump from EX.
- redirect_base_i  in  XLEN  target base (PC for branch/JAL, rs1 for JALR).
- redirect_offset_i  in  XLEN  sign-extended immediate.
- redirect_jalr_i  in  1  clear bit 0 of computed target.
- trap_valid_i  in  1  trap/exception redirect.
- trap_vector_i  in  XLEN  trap handler address.
- pc_o  out  XLEN  current fetch PC.
- pc_plus_o  out  XLEN  pc_o + INC (combinational from pc_o, for link register).
- pc_valid_o  out  1  pc_o is a valid fetch request.
- flush_o  out  1  one-cycle pulse: younger IF/ID contents must be squashed.
- redirect_cnt_o  out  16  count of applied redirects + traps, saturating.

Behaviour:
- Reset (rst=1 at edge): pc_o=RESET_VEC, pc_valid_o=0, flush_o=0, redirect_cnt_o=0, state=BOOT, boot counter=0. Reset mid-operation overrides every other input in that cycle.
- FSM states:
  - BOOT: counts BOOT_CYCLES, then moves to RUN. pc_valid_o=0; redirects and traps ignored.
  - RUN: pc_valid_o=1.
  - HOLD: entered from RUN when stall_i=1 or (pc_valid_o=1 and fetch_ready_i=0). pc_valid_o stays 1 and pc_o is unchanged. Returns to RUN on the first cycle with stall_i=0 and fetch_ready_i=1.
- Next-PC priority in RUN/HOLD, evaluated each cycle, registered at the edge (1-cycle latency):
  1. trap_valid_i -> trap_vector_i.
  2. redirect_valid_i -> target. target = (redirect_base_i + redirect_offset_i) mod 2^XLEN; bit 0 forced to 0 when redirect_jalr_i=1.
  3. stall_i -> hold.
  4. fetch_ready_i=1 -> pc_o + INC, mod 2^XLEN (all-ones region wraps to 0).
  5. otherwise -> hold.
- Trap/redirect override stall and an unaccepted handshake. The pending request is abandoned, not replayed. The next state is RUN.
- flush_o=1 in the cycle after a trap or redirect is applied, else 0.
- redirect_cnt_o increments by 1 per applied trap or redirect and saturates at 16'hFFFF. Simultaneous trap+redirect counts 1.
- pc_o is stable while pc_valid_o=1 and fetch_ready_i=0 (AXI-style hold rule) unless a trap or redirect is applied.
- All adders are XLEN-wide with the carry discarded. No X on any output after reset.

Optional Feature:
- Macro PC_GEN_MISALIGN_TRAP_EN.
- Defined: adds output misalign_o (1 bit, reset 0), and any computed redirect target with bits [1:0] != 0 (after the JALR clear) is misaligned. On a misaligned target, PC is not updated and redirect_cnt_o is not incremented. misalign_o pulses 1 for one cycle (same timing as flush_o), and flush_o still pulses. The trap unit then supplies trap_valid_i.
- Undefined: port absent; misaligned targets are loaded as computed.

Test Plan:
- Reset release, BOOT_CYCLES=1, fetch_ready_i=1 -> pc_o=0x0 with pc_valid_o=0 for 1 cycle, then 0x0, 0x4, 0x8 on consecutive cycles; pc_plus_o=0xC when pc_o=0x8.
- pc_o=0x100, fetch_ready_i=0 for 3 cycles, then 1 -> pc_o holds 0x100 for 3 cycles, then 0x104; stall_i=1 with ready=1 likewise holds.
- Redirect base=0x200, offset=0xFFFF_FFF0 (-16), jalr=0 during stall -> next pc_o=0x1F0, flush_o=1 for one cycle, redirect_cnt_o+1; jalr=1, base=0x301, offset=0 -> 0x300.
- Trap vector 0x8000_0000 and redirect 0x400 in the same cycle -> pc_o=0x8000_0000, redirect_cnt_o increments by exactly 1.
- pc_o=0xFFFF_FFFC, ready=1 -> pc_o wraps to 0x0; 65536 redirects -> redirect_cnt_o stays 0xFFFF.
- rst asserted mid-HOLD with redirect_valid_i=1 -> pc_o=RESET_VEC, pc_valid_o=0, flush_o=0, count=0. With PC_GEN_MISALIGN_TRAP_EN, target 0x202 -> pc_o unchanged, misalign_o=1 for one cycle.
